// File: rtl/dpr_pkg.sv
// Shared types and constants for the dual-port RAM loader family.
package dpr_pkg;

  localparam int IOCTL_AW = 25;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    VERIFY,
    DONE
  } state_t;

  function automatic int aw_from_kb(input int kb);
    return $clog2(kb * 1024);
  endfunction

endpackage

// File: rtl/dpr_addr_check.sv
// Effective-address computation and RAM range check for one download index.
module dpr_addr_check
  import dpr_pkg::*;
#(
  parameter int KB   = 16,
  parameter int BASE = 0,
  parameter int AW   = aw_from_kb(KB)
) (
  input  logic [IOCTL_AW-1:0] addr,
  output logic [AW-1:0]       ea,
  output logic                in_range
);

  // One extra bit so addr + BASE can never wrap back into range.
  localparam int EA_W = IOCTL_AW + 1;
  localparam logic [EA_W-1:0] RAM_BYTES = EA_W'(KB * 1024);
  localparam logic [EA_W-1:0] BASE_EXT  = EA_W'(BASE);

  logic [EA_W-1:0] ea_full;

  always_comb begin
    ea_full  = {1'b0, addr} + BASE_EXT;
    ea       = ea_full[AW-1:0];
    in_range = ea_full < RAM_BYTES;
  end

endmodule

// File: rtl/dpr_loader.sv
// Port-2 write client for the core's 8-bit dual-port RAM, fed by the HPS ioctl stream.
// Define DPR_LOADER_VERIFY_EN to read back and compare every written byte.
module dpr_loader
  import dpr_pkg::*;
#(
  parameter int KB    = 16,
  parameter int INDEX = 0,
  parameter int BASE  = 0,
  localparam int AW   = aw_from_kb(KB)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ioctl_download,
  input  logic [7:0]          ioctl_index,
  input  logic                ioctl_wr,
  input  logic [IOCTL_AW-1:0] ioctl_addr,
  input  logic [7:0]          ioctl_dout,
  output logic                ioctl_wait,
  output logic [AW-1:0]       a2,
  output logic [7:0]          d2,
  output logic                w2,
  input  logic [7:0]          q2,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [AW:0]         count
`ifdef DPR_LOADER_VERIFY_EN
  ,
  output logic                verify_err
`endif
);

  localparam logic [AW:0] COUNT_FULL = {1'b1, {AW{1'b0}}};

  state_t        state, state_d;
  logic [AW-1:0] ea, a2_d;
  logic [7:0]    d2_d;
  logic [AW:0]   count_d;
  logic          in_range, match, byte_end, finish;
  logic          wait_d, w2_d, busy_d, done_d, overflow_d;

`ifdef DPR_LOADER_VERIFY_EN
  logic verify_err_d, settle, settle_d;
`else
  logic unused_q2;
  assign unused_q2 = ^q2;
`endif

  dpr_addr_check #(.KB(KB), .BASE(BASE), .AW(AW)) u_addr_check (
    .addr    (ioctl_addr),
    .ea      (ea),
    .in_range(in_range)
  );

  assign match = ioctl_download && (ioctl_index == 8'(INDEX));

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latches).
    state_d    = state;
    a2_d       = a2;
    d2_d       = d2;
    w2_d       = 1'b0;
    wait_d     = ioctl_wait;
    busy_d     = busy;
    done_d     = 1'b0;
    overflow_d = overflow;
    count_d    = count;
    byte_end   = 1'b0;
    finish     = 1'b0;
`ifdef DPR_LOADER_VERIFY_EN
    verify_err_d = verify_err;
    settle_d     = 1'b0;
`endif

    unique case (state)
      IDLE: begin
        if (match) begin
          state_d    = LOAD;
          busy_d     = 1'b1;
          count_d    = '0;
          overflow_d = 1'b0;
`ifdef DPR_LOADER_VERIFY_EN
          verify_err_d = 1'b0;
`endif
        end
      end
      LOAD: begin
        if (ioctl_wr && in_range) begin
          a2_d    = ea;
          d2_d    = ioctl_dout;
          w2_d    = 1'b1;
          wait_d  = 1'b1;
          state_d = WRITE;
        end else begin
          if (ioctl_wr) overflow_d = 1'b1;
          if (!ioctl_download) finish = 1'b1;
        end
      end
      WRITE: begin
        if (count != COUNT_FULL) count_d = count + 1'b1;
`ifdef DPR_LOADER_VERIFY_EN
        state_d = VERIFY;
`else
        byte_end = 1'b1;
`endif
      end
`ifdef DPR_LOADER_VERIFY_EN
      VERIFY: begin
        // First cycle covers the RAM read latency; q2 is valid in the second.
        settle_d = !settle;
        if (settle) begin
          if (q2 != d2) verify_err_d = 1'b1;
          byte_end = 1'b1;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (byte_end) begin
      wait_d = 1'b0;
      if (ioctl_download) state_d = LOAD;
      else                finish  = 1'b1;
    end
    if (finish) begin
      state_d = DONE;
      done_d  = 1'b1;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state      <= IDLE;
      a2         <= '0;
      d2         <= '0;
      w2         <= 1'b0;
      ioctl_wait <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      count      <= '0;
`ifdef DPR_LOADER_VERIFY_EN
      verify_err <= 1'b0;
      settle     <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      a2         <= a2_d;
      d2         <= d2_d;
      w2         <= w2_d;
      ioctl_wait <= wait_d;
      busy       <= busy_d;
      done       <= done_d;
      overflow   <= overflow_d;
      count      <= count_d;
`ifdef DPR_LOADER_VERIFY_EN
      verify_err <= verify_err_d;
      settle     <= settle_d;
`endif
    end
  end

endmodule

// File: doc/dpr_loader.md
Name: dpr_loader

Overview:
- Write-side client for the core's 8-bit dual-port RAM (port 2: address, data, write strobe, readback).
- Takes the HPS download byte stream (ioctl_*), filters it by index and writes each byte into RAM with a one-cycle write strobe.
- Throttles the host with a wait signal, keeps the CPU held while loading, and reports completion and overflow status.
- Sits between the HPS I/O block and the ROM/RAM dual-port instance; port 1 stays with the CPU and video.

Parameters:
KB, 16, RAM size in KiB; address width AW = $clog2(KB*1024)
INDEX, 0, ioctl_index value accepted; other indices are ignored
BASE, 0, byte offset added to ioctl_addr before the range check

Ports:
clock  in  1  system clock; all logic on the rising edge
reset  in  1  synchronous, active-low reset
ioctl_download  in  1  host download window active
ioctl_index  in  8  download target index
ioctl_wr  in  1  one-cycle byte-valid strobe
ioctl_addr  in  25  byte address within the download
ioctl_dout  in  8  byte data
ioctl_wait  out  1  host must hold the next ioctl_wr while high
a2  out  AW  RAM port-2 address
d2  out  8  RAM port-2 write data
w2  out  1  RAM port-2 write strobe
q2  in  8  RAM port-2 read data; used only with the optional feature
busy  out  1  high while a matching download is active; holds the CPU in reset
done  out  1  one-cycle pulse when a matching download ends
overflow  out  1  sticky; set when a byte address is at or beyond KB*1024
count  out  AW+1  number of bytes written in the current or last download

Behaviour:
- Reset (reset=0 at a clock edge) forces all outputs to 0: ioctl_wait, a2, d2, w2, busy, done, overflow, count. State goes to IDLE.
- A reset during LOAD or WRITE aborts the load. done is not pulsed. RAM contents already written stay as written.
- match = ioctl_download && (ioctl_index == INDEX).
- Effective address ea = ioctl_addr + BASE, computed at 26 bits with no wrap.
- IDLE:
  - On match: go to LOAD; busy=1; count=0; overflow=0.
- LOAD:
  - On ioctl_wr with ea < KB*1024: latch a2=ea[AW-1:0] and d2=ioctl_dout; ioctl_wait=1; go to WRITE.
  - On ioctl_wr with ea >= KB*1024: byte dropped; overflow=1; no wait; stay in LOAD.
  - On !ioctl_download: go to DONE. A download-low and ioctl_wr in the same cycle: the byte is accepted first and the exit is taken from WRITE.
- WRITE:
  - Exactly one cycle with w2=1.
  - Next cycle: w2=0, count+1, ioctl_wait=0.
  - Then return to LOAD, or go to DONE if ioctl_download is already low.
- DONE:
  - done=1 for one cycle; busy=0; go to IDLE.
  - count and overflow hold their values until the next matching download starts.
- ioctl_wait timing: rises in the cycle after the accepted ioctl_wr and stays high through the write. A new byte is accepted no sooner than 2 cycles after the previous one.
- Any ioctl_wr while in WRITE is a protocol error and is ignored.
- ioctl_index changing mid-download has no effect; the match is evaluated only in IDLE.
- count saturates at 2^AW, which equals full RAM.
- a2 and d2 hold their last values outside WRITE.

Optional Feature:
- Macro: DPR_LOADER_VERIFY_EN.
- With the macro: after the w2 cycle, the FSM enters VERIFY.
  - It drives the same a2 with w2=0 and waits 1 cycle for RAM read latency.
  - It then compares q2 with d2.
  - On mismatch it sets a sticky output verify_err (1 bit, reset 0, cleared at the start of a download).
  - ioctl_wait stays high through VERIFY; byte spacing becomes 4 cycles.
- Without the macro: no VERIFY state, no verify_err port, q2 is unused.

Decomposition:
- Shared package dpr_pkg:
  - state enum (IDLE, LOAD, WRITE, VERIFY, DONE)
  - IOCTL_AW=25 constant
  - function for AW from KB
- One natural sub-module: dpr_addr_check. Combinational ea computation plus in-range flag, reused by future multi-index loaders.

Test Plan:
- Reset mid-write: reset=0 during WRITE -> next cycle w2=0, busy=0, ioctl_wait=0; no done pulse.
- Basic load: KB=16, INDEX=0, bytes 0x11,0x22,0x33 at addr 0..2 -> three single-cycle w2 pulses; RAM[0..2]=11,22,33; count=3; done pulse 1 cycle after download falls; busy 0.
- Index filter: download with index 1 -> no w2, busy stays 0, count unchanged.
- Overflow: KB=1, BASE=0x3FE, addr 0..3 -> writes land at 0x3FE and 0x3FF only; overflow=1; count=2.
- Back-to-back strobes: ioctl_wr every cycle -> the second strobe during WRITE is ignored. With the host honouring wait, every byte is written and w2 fires every 2 cycles.
- Verify (macro on): force q2 to read 0x00 for a written 0x5A -> verify_err=1 and stays set until the next download starts.
